uart_tx_scheduler: RTL and testbench

Sequences the shared RS485 UART frame transmitter. It takes frame-transmit requests from N_REQ requesters and grants one at a time, round-robin. It drives the transmitter's level RQ handshake, supervises completion through the transmitter's dirRX line, enforces an inter-frame bus gap, and maintains the 5-bit frame cycle number fed to the transmitter. It also flags requests that the transmitter never acknowledges.

---
 rtl/uart_sched_pkg.sv | 18 +
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 137 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and default constants for the RS485 UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } sched_state_e;

    typedef logic [4:0] cycle_t;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_GAP_CYCLES = 64;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_CYCLE_MOD  = 20;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the requesters/transmitter (master side) and the scheduler (slave side).
// Handshake: rq is a level request held from grant until busy_in (transmitter dirRX) has risen
// and fallen again; busy_in is asynchronous, and rq may also drop without busy on a timeout.
interface uart_tx_scheduler_if
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
);
    logic [N_REQ-1:0] req;
    logic             busy_in;
    logic             rq;
    logic [N_REQ-1:0] grant;
    cycle_t           cycle;
    logic             frame_done;
    logic             timeout_err;
    sched_state_e     state;

    modport master (
        output req, busy_in,
        input  rq, grant, cycle, frame_done, timeout_err, state
    );

    modport slave (
        input  req, busy_in,
        output rq, grant, cycle, frame_done, timeout_err, state
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping past N-1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Grants the shared RS485 frame transmitter round-robin, supervises each frame through the
// synchronised dirRX line, enforces the inter-frame gap and keeps the frame cycle number.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CYCLE_MOD  = DEF_CYCLE_MOD
) (
    input logic               clk,
    input logic               reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [IW-1:0] PTR_LAST = IW'(N_REQ - 1);
    localparam logic [15:0]   WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam cycle_t        CYC_LAST = cycle_t'(CYCLE_MOD - 1);

    if (CYCLE_MOD < 1 || CYCLE_MOD > 32) begin : g_bad_cycle_mod
        $error("uart_tx_scheduler: CYCLE_MOD must lie in 1..32");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_scheduler: N_REQ must lie in 2..8");
    end

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, pick_idx;
    logic [N_REQ-1:0] grant_q, grant_d, pick_grant;
    logic             pick_found;
    logic [15:0]      wd_q, wd_d, gap_q, gap_d;
    cycle_t           cycle_q, cycle_d;
    logic             rq_q, rq_d, done_q, done_d, tmo_q, tmo_d;
    logic             busy_m, busy_s;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // dirRX comes from the transmitter's clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= bus.busy_in;
            busy_s <= busy_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            cycle_q <= '0;
            rq_q    <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            cycle_q <= cycle_d;
            rq_q    <= rq_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        cycle_d = cycle_q;
        rq_d    = rq_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_grant;
                    ptr_d   = (pick_idx == PTR_LAST) ? '0 : pick_idx + IW'(1);
                    rq_d    = 1'b1;
                    wd_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                wd_d = wd_q + 16'd1;
                // an acknowledge arriving on the last watchdog clock still wins
                if (busy_s) begin
                    state_d = XFER;
                end else if (wd_q == WD_LAST) begin
                    rq_d    = 1'b0;
                    grant_d = '0;
                    tmo_d   = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            XFER: begin
                if (!busy_s) begin
                    rq_d    = 1'b0;
                    grant_d = '0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    cycle_d = (cycle_q == CYC_LAST) ? '0 : cycle_q + cycle_t'(1);
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 16'd1;
                if (gap_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rq          = rq_q;
    assign bus.grant       = grant_q;
    assign bus.cycle       = cycle_q;
    assign bus.frame_done  = done_q;
    assign bus.timeout_err = tmo_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: randomized frames against a round-robin/cycle
// reference model, plus timeout, gap, reset and spurious-busy scenarios.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int N_REQ      = 4;
    localparam int GAP_CYCLES = 64;
    localparam int TIMEOUT    = 1024;
    localparam int CYCLE_MOD  = 20;
    // gap clocks plus the IDLE clock that samples req again
    localparam int GAP_LOW    = GAP_CYCLES + 1;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_ptr    = 0;
    int   m_cycle  = 0;
    logic [N_REQ-1:0] exp_q[$];

    uart_tx_scheduler_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_scheduler #(
        .N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .CYCLE_MOD(CYCLE_MOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N_REQ-1:0] model_pick(input logic [N_REQ-1:0] r);
        logic [N_REQ-1:0] g;
        g = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (r[i]) begin
                g[i]  = 1'b1;
                m_ptr = (i + 1) % N_REQ;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_cycle = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        bus.req     = '0;
        bus.busy_in = 1'b0;
        reset       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.req = '0;
        repeat (GAP_CYCLES + 5) @(negedge clk);
    endtask

    task automatic wait_rq(input int budget, output bit ok, output int waited);
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            if (bus.rq === 1'b1) ok = 1'b1;
            else waited++;
        end
    endtask

    // Transmitter model: busy rises dly clocks after rq is seen, stays len clocks, then falls.
    task automatic xmit_frame(input int dly, input int len, input bit drop_req,
                              output bit rq_ok, output int rq_wait, output logic [N_REQ-1:0] g_seen,
                              output bit g_stable, output int done_cnt, output int tmo_cnt,
                              output int low_after);
        bit seen;
        done_cnt = 0; tmo_cnt = 0; low_after = 0; g_stable = 1'b1; seen = 1'b0;
        wait_rq(2000, rq_ok, rq_wait);
        g_seen = bus.grant;
        if (!rq_ok) return;
        for (int i = 1; i <= dly + len; i++) begin
            @(negedge clk);
            if (bus.timeout_err === 1'b1) tmo_cnt++;
            if (bus.grant !== g_seen || bus.rq !== 1'b1) g_stable = 1'b0;
            if (drop_req && i == 1) bus.req = '0;
            if (i == dly) bus.busy_in = 1'b1;
        end
        bus.busy_in = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.timeout_err === 1'b1) tmo_cnt++;
            if (bus.frame_done === 1'b1) begin
                seen = 1'b1;
                done_cnt++;
                if (bus.rq === 1'b0) low_after++;
            end
        end
        if (seen) begin
            repeat (3) begin
                @(negedge clk);
                if (bus.frame_done === 1'b1) done_cnt++;
                if (bus.rq === 1'b0) low_after++;
            end
        end
    endtask

    task automatic test_reset();
        bus.req = '0; bus.busy_in = 1'b0; reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.rq !== 1'b0) begin n_fail++; $display("FAIL reset_rq: got %b expected 0", bus.rq); end
        n_checks++; if (bus.grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        n_checks++; if (bus.cycle !== 5'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", bus.cycle); end
        n_checks++; if (bus.frame_done !== 1'b0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b tmo=%b expected 0 0", bus.frame_done, bus.timeout_err); end
        n_checks++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
        bus.req = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.rq !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got rq=%b expected 0 while reset low", bus.rq); end
        bus.req = '0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok, stab; int wt, done, tmo, low, waited; logic [N_REQ-1:0] g, e;
        bus.req = 4'b0001;
        exp_q.push_back(model_pick(bus.req));
        xmit_frame(20, 200, 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (!ok || wt != 0) begin n_fail++; $display("FAIL single_latency: got ok=%b wait=%0d expected ok=1 wait=0", ok, wt); end
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL single_grant: got %b expected %b", g, e); end
        n_checks++; if (!stab) begin n_fail++; $display("FAIL single_hold: got unstable grant/rq expected held"); end
        n_checks++; if (done != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses expected 1", done); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL single_cycle: got %0d expected %0d", bus.cycle, m_cycle); end
        wait_rq(200, ok, waited);
        n_checks++; if (!ok || low + waited != GAP_LOW) begin n_fail++; $display("FAIL single_gap: got %0d low clocks expected %0d", low + waited, GAP_LOW); end
        exp_q.push_back(model_pick(bus.req));
        xmit_frame($urandom_range(1, 8), $urandom_range(2, 30), 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (g !== e || done != 1) begin n_fail++; $display("FAIL single_regrant: got grant=%b done=%0d expected grant=%b done=1", g, done, e); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL single_cycle2: got %0d expected %0d", bus.cycle, m_cycle); end
        drain();
    endtask

    task automatic test_round_robin();
        bit ok, stab; int wt, done, tmo, low; logic [N_REQ-1:0] g, e;
        apply_reset();
        bus.req = '1;
        for (int f = 0; f < 8; f++) begin
            exp_q.push_back(model_pick(bus.req));
            xmit_frame($urandom_range(1, 8), $urandom_range(2, 30), 1'b0, ok, wt, g, stab, done, tmo, low);
            e = exp_q.pop_front();
            m_cycle = (m_cycle + 1) % CYCLE_MOD;
            n_checks++; if (!ok || g !== e) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", f, g, e); end
            n_checks++; if (done != 1) begin n_fail++; $display("FAIL rr_done[%0d]: got %0d expected 1", f, done); end
            n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", f, bus.cycle, m_cycle); end
        end
        n_checks++; if (bus.cycle !== 5'd8) begin n_fail++; $display("FAIL rr_final_cycle: got %0d expected 8", bus.cycle); end
        drain();
    endtask

    task automatic test_timeout();
        bit ok, stab; int waited, n, low, wt, done, tmo; logic [N_REQ-1:0] g, e;
        bus.req = 4'b0100; bus.busy_in = 1'b0;
        e = model_pick(bus.req);
        wait_rq(10, ok, waited);
        n_checks++; if (!ok || bus.grant !== e) begin n_fail++; $display("FAIL tmo_grant: got rq=%b grant=%b expected 1 %b", ok, bus.grant, e); end
        n = 0;
        while (n < TIMEOUT + 20 && bus.timeout_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n != TIMEOUT) begin n_fail++; $display("FAIL tmo_latency: got %0d clocks expected %0d", n, TIMEOUT); end
        n_checks++; if (bus.rq !== 1'b0 || bus.grant !== '0) begin n_fail++; $display("FAIL tmo_release: got rq=%b grant=%b expected 0 0000", bus.rq, bus.grant); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL tmo_cycle: got %0d expected %0d", bus.cycle, m_cycle); end
        low = (bus.rq === 1'b0) ? 1 : 0;
        @(negedge clk);
        n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 0 one clock later", bus.timeout_err); end
        if (bus.rq === 1'b0) low++;
        wait_rq(200, ok, waited);
        n_checks++; if (!ok || low + waited != GAP_LOW) begin n_fail++; $display("FAIL tmo_gap: got %0d low clocks expected %0d", low + waited, GAP_LOW); end
        exp_q.push_back(model_pick(bus.req));
        xmit_frame($urandom_range(1, 8), $urandom_range(2, 20), 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (g !== e || done != 1) begin n_fail++; $display("FAIL tmo_regrant: got grant=%b done=%0d expected %b 1", g, done, e); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL tmo_cycle2: got %0d expected %0d", bus.cycle, m_cycle); end
        drain();
    endtask

    task automatic test_timeout_boundary();
        bit ok, stab; int wt, done, tmo, low; logic [N_REQ-1:0] g, e;
        // busy_s reaches the FSM on exactly the last watchdog clock
        bus.req = 4'b0001;
        exp_q.push_back(model_pick(bus.req));
        xmit_frame(TIMEOUT - 3, 6, 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (tmo != 0 || done != 1 || g !== e) begin n_fail++; $display("FAIL edge_busy_wins: got tmo=%0d done=%0d grant=%b expected 0 1 %b", tmo, done, g, e); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL edge_cycle: got %0d expected %0d", bus.cycle, m_cycle); end
        drain();
        // one clock later the watchdog fires first; the late busy lands in GAP
        bus.req = 4'b0010;
        exp_q.push_back(model_pick(bus.req));
        xmit_frame(TIMEOUT - 2, 10, 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        n_checks++; if (tmo != 1 || done != 0 || g !== e) begin n_fail++; $display("FAIL edge_late_busy: got tmo=%0d done=%0d grant=%b expected 1 0 %b", tmo, done, g, e); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL edge_late_cycle: got %0d expected %0d", bus.cycle, m_cycle); end
        drain();
    endtask

    task automatic test_cycle_wrap();
        bit ok, stab; int wt, done, tmo, low; logic [N_REQ-1:0] g, e, r;
        apply_reset();
        for (int f = 0; f < CYCLE_MOD; f++) begin
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            bus.req = r;
            exp_q.push_back(model_pick(r));
            xmit_frame($urandom_range(1, 4), $urandom_range(2, 12), 1'b0, ok, wt, g, stab, done, tmo, low);
            e = exp_q.pop_front();
            m_cycle = (m_cycle + 1) % CYCLE_MOD;
            n_checks++; if (!ok || g !== e || done != 1) begin n_fail++; $display("FAIL wrap_frame[%0d]: got grant=%b done=%0d expected %b 1", f, g, done, e); end
            n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL wrap_cycle[%0d]: got %0d expected %0d", f, bus.cycle, m_cycle); end
        end
        n_checks++; if (bus.cycle !== 5'd0) begin n_fail++; $display("FAIL wrap_final: got %0d expected 0", bus.cycle); end
        drain();
    endtask

    task automatic test_reset_mid_xfer();
        bit ok, stab; int wt, done, tmo, low, waited; logic [N_REQ-1:0] g, e;
        bus.req = 4'b1000;
        exp_q.push_back(model_pick(bus.req));
        xmit_frame(2, 5, 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (g !== e || bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL rst_pre: got grant=%b cycle=%0d expected %b %0d", g, bus.cycle, e, m_cycle); end
        wait_rq(200, ok, waited);
        repeat (2) @(negedge clk);
        bus.busy_in = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (bus.state !== XFER) begin n_fail++; $display("FAIL rst_in_xfer: got state %0d expected %0d", bus.state, XFER); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (bus.rq !== 1'b0 || bus.grant !== '0 || bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL rst_async: got rq=%b grant=%b cycle=%0d expected 0 0000 0", bus.rq, bus.grant, bus.cycle); end
        bus.busy_in = 1'b0;
        @(negedge clk);
        bus.req = 4'b0010;
        reset = 1'b1;
        e = model_pick(bus.req);
        wait_rq(5, ok, waited);
        n_checks++; if (!ok || waited != 0 || bus.grant !== e) begin n_fail++; $display("FAIL rst_first_grant: got rq=%b grant=%b expected 1 %b", ok, bus.grant, e); end
        xmit_frame(3, 5, 1'b0, ok, wt, g, stab, done, tmo, low);
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (g !== e || done != 1 || bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL rst_post_frame: got grant=%b done=%0d cycle=%0d expected %b 1 %0d", g, done, bus.cycle, e, m_cycle); end
        drain();
    endtask

    task automatic test_spurious_and_drop();
        bit ok, stab, quiet; int wt, done, tmo, low, waited; logic [N_REQ-1:0] g, e;
        bus.req = 4'b0001;
        exp_q.push_back(model_pick(bus.req));
        xmit_frame(4, 10, 1'b1, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (!ok || g !== e || !stab) begin n_fail++; $display("FAIL drop_grant: got grant=%b held=%b expected %b 1", g, stab, e); end
        n_checks++; if (done != 1 || bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL drop_done: got done=%0d cycle=%0d expected 1 %0d", done, bus.cycle, m_cycle); end
        bus.req = 4'b0010;
        quiet = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.busy_in = (i < 3);
            @(negedge clk);
            if (bus.state !== GAP || bus.rq !== 1'b0 || bus.frame_done !== 1'b0) quiet = 1'b0;
            if (bus.rq === 1'b0) low++;
        end
        bus.busy_in = 1'b0;
        n_checks++; if (!quiet) begin n_fail++; $display("FAIL spurious_busy: got activity during GAP expected none"); end
        wait_rq(200, ok, waited);
        n_checks++; if (!ok || low + waited != GAP_LOW) begin n_fail++; $display("FAIL spurious_gap: got %0d low clocks expected %0d", low + waited, GAP_LOW); end
        n_checks++; if (bus.cycle !== 5'(m_cycle)) begin n_fail++; $display("FAIL spurious_cycle: got %0d expected %0d", bus.cycle, m_cycle); end
        exp_q.push_back(model_pick(bus.req));
        xmit_frame($urandom_range(1, 6), $urandom_range(2, 10), 1'b0, ok, wt, g, stab, done, tmo, low);
        e = exp_q.pop_front();
        m_cycle = (m_cycle + 1) % CYCLE_MOD;
        n_checks++; if (g !== e || done != 1) begin n_fail++; $display("FAIL spurious_next: got grant=%b done=%0d expected %b 1", g, done, e); end
        drain();
    endtask

    initial begin
        bus.req     = '0;
        bus.busy_in = 1'b0;
        reset       = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_timeout_boundary();
        test_cycle_wrap();
        test_reset_mid_xfer();
        test_spurious_and_drop();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
